// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order write-back FIFO with register-file drain and read forwarding (enabled by WBQ_FWD_EN)
module wb_write_queue #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ADDR_W-1:0]         in_addr,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      wr_hold,
   output logic                      write_back,
   output logic [ADDR_W-1:0]         write_addr,
   output logic [DATA_W-1:0]         write_data,
   input  logic [ADDR_W-1:0]         src_addr,
   input  logic [ADDR_W-1:0]         dst_addr,
   output logic                      fwd_hit1,
   output logic                      fwd_hit2,
   output logic [DATA_W-1:0]         fwd_data1,
   output logic [DATA_W-1:0]         fwd_data2,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     head, tail;
   logic              push, pop;
   assign pop        = (count != '0) && !wr_hold;
   assign in_ready   = (count < CW'(DEPTH)) || pop;
   assign push       = in_valid && in_ready;
   assign write_back = pop;
   assign write_addr = pop ? addr_q[head] : '0;
   assign write_data = pop ? data_q[head] : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (push) begin
            addr_q[tail] <= in_addr;
            data_q[tail] <= in_data;
            tail         <= tail + 1'b1;
         end
         if (pop) head <= head + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
`ifdef WBQ_FWD_EN
   // Walk oldest to newest so the newest matching entry overwrites earlier hits.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = '0;
      fwd_data2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count) begin
            if (addr_q[head + PW'(i)] == dst_addr) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = data_q[head + PW'(i)];
            end
            if (addr_q[head + PW'(i)] == src_addr) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = data_q[head + PW'(i)];
            end
         end
      end
   end
`else
   logic unused_rd_addr;
   assign unused_rd_addr = ^{src_addr, dst_addr};
   assign fwd_hit1  = 1'b0;
   assign fwd_hit2  = 1'b0;
   assign fwd_data1 = '0;
   assign fwd_data2 = '0;
`endif
endmodule
